// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab CPU: opcodes, control states and
// instruction field positions.
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_LW  = 2'd1;
  localparam logic [1:0] OP_SW  = 2'd2;
  localparam logic [1:0] OP_JMP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_t;

  // Instruction format: op[7:6] rs[5:4] rt[3:2] rd/imm[1:0]
  localparam int unsigned OP_HI  = 7;
  localparam int unsigned OP_LO  = 6;
  localparam int unsigned RS_HI  = 5;
  localparam int unsigned RS_LO  = 4;
  localparam int unsigned RT_HI  = 3;
  localparam int unsigned RT_LO  = 2;
  localparam int unsigned RD_HI  = 1;
  localparam int unsigned RD_LO  = 0;
  localparam int unsigned TGT_HI = 5;
  localparam int unsigned TGT_LO = 0;

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the final allowed one.
module wait_timer #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  // High during the LIMIT-th consecutive stalled cycle.
  assign o_expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 8-bit lab CPU, with run/step control,
// memory timeout fault and a retired-instruction counter.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter bit          RUN_AT_RESET = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       instruction,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             jump,
  output logic             ir_write,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             alusrc,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic [2:0]       state,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TMR_W = 8;

  state_t           r_state;
  state_t           w_next;
  state_t           w_end_state;
  logic [1:0]       r_op;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_wait_inc;
  logic             w_expired;
  logic             w_unused;

  assign w_unused = ^instruction[TGT_HI:TGT_LO];

  wait_timer #(.LIMIT(MEM_TIMEOUT), .W(TMR_W)) u_wait_timer (
    .clk       (CLK),
    .rst       (RESET),
    .i_clr     (!w_wait_inc),
    .i_inc     (w_wait_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= RUN_AT_RESET ? ST_FETCH : ST_IDLE;
      r_op      <= OP_ADD;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (ir_write) r_op <= instruction[OP_HI:OP_LO];
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      if (w_next == ST_FAULT) r_fault <= 1'b1;
    end
  end

  assign w_end_state = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_wait_inc = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    ir_write   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run || step) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        if (r_op == OP_JMP) begin
          pc_write = 1'b1;
          jump     = 1'b1;
          w_retire = 1'b1;
          w_next   = w_end_state;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alusrc = (r_op != OP_ADD);
        w_next = (r_op == OP_ADD) ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        iord     = 1'b1;
        memread  = (r_op == OP_LW);
        memwrite = (r_op == OP_SW);
        if (mem_ready) begin
          if (r_op == OP_LW) begin
            w_next = ST_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = w_end_state;
          end
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        regwrite = 1'b1;
        regdst   = (r_op == OP_ADD);
        memtoreg = (r_op == OP_LW);
        w_retire = 1'b1;
        w_next   = w_end_state;
      end
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FAULT;
    endcase
  end

  assign state   = r_state;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against an
// instruction-plan reference model; a CNT_W=4 copy checks counter wrap.
module tb_multicycle_control;

  localparam int TMO = 15;

  logic       CLK = 1'b0;
  logic       RESET, run, step, mem_ready;
  logic [7:0] instruction;

  logic        pc_write, jump, ir_write, memread, memwrite, iord, alusrc;
  logic        regdst, memtoreg, regwrite, busy, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        e_pc_write, e_jump, e_ir_write, e_memread, e_memwrite, e_iord;
  logic        e_alusrc, e_regdst, e_memtoreg, e_regwrite, e_busy, e_fault;
  logic [2:0]  e_state;
  logic [3:0]  e_retired;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_op, m_wait, m_ret;
  bit m_fault;
  int m_q[$];

  always #5 CLK = ~CLK;

  multicycle_control #(.CNT_W(16), .MEM_TIMEOUT(TMO), .RUN_AT_RESET(1'b1)) u_dut (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .instruction(instruction),
    .mem_ready(mem_ready), .pc_write(pc_write), .jump(jump), .ir_write(ir_write),
    .memread(memread), .memwrite(memwrite), .iord(iord), .alusrc(alusrc),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .state(state),
    .busy(busy), .fault(fault), .retired(retired)
  );

  multicycle_control #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .run(run), .step(step), .instruction(instruction),
    .mem_ready(mem_ready), .pc_write(e_pc_write), .jump(e_jump), .ir_write(e_ir_write),
    .memread(e_memread), .memwrite(e_memwrite), .iord(e_iord), .alusrc(e_alusrc),
    .regdst(e_regdst), .memtoreg(e_memtoreg), .regwrite(e_regwrite), .state(e_state),
    .busy(e_busy), .fault(e_fault), .retired(e_retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe vector {pc_write,jump,ir_write,memread,memwrite,iord,alusrc,regdst,memtoreg,regwrite}
  function automatic logic [9:0] exp_strobes();
    bit pw = 0, jp = 0, irw = 0, mr = 0, mw = 0, io = 0, as = 0, rd = 0, mt = 0, rw = 0;
    case (m_st)
      1: begin mr = 1; irw = mem_ready; pw = mem_ready; end
      2: if (m_op == 3) begin pw = 1; jp = 1; end
      3: as = (m_op != 0);
      4: begin io = 1; mr = (m_op == 1); mw = (m_op == 2); end
      5: begin rw = 1; rd = (m_op == 0); mt = (m_op == 1); end
      default: ;
    endcase
    return {pw, jp, irw, mr, mw, io, as, rd, mt, rw};
  endfunction

  task automatic model_reset();
    m_st = 1; m_op = 0; m_wait = 0; m_ret = 0; m_fault = 0;
    m_q.delete();
  endtask

  // Move to the next planned phase, or retire when the plan is exhausted.
  task automatic model_advance();
    if (m_q.size() == 0) begin
      m_ret++;
      m_st   = run ? 1 : 0;
      m_wait = 0;
    end else begin
      m_st = m_q.pop_front();
      if (m_st == 4) m_wait = 0;
    end
  endtask

  task automatic model_clock();
    case (m_st)
      0: if (run || step) begin m_st = 1; m_wait = 0; end
      1, 4: begin
        if (mem_ready) begin
          if (m_st == 1) begin
            m_op = int'(instruction[7:6]);
            m_q.delete();
            m_q.push_back(2);
            if (m_op != 3) m_q.push_back(3);
            if (m_op == 1 || m_op == 2) m_q.push_back(4);
            if (m_op == 0 || m_op == 1) m_q.push_back(5);
          end
          model_advance();
        end else begin
          m_wait++;
          if (m_wait >= TMO) begin m_st = 7; m_fault = 1; end
        end
      end
      7: ;
      default: model_advance();
    endcase
  endtask

  task automatic check_now();
    chk("strobes", 32'({pc_write, jump, ir_write, memread, memwrite, iord, alusrc,
                        regdst, memtoreg, regwrite}), 32'(exp_strobes()));
    chk("state", 32'(state), 32'(m_st));
    chk("busy", 32'(busy), 32'(m_st != 0 && m_st != 7));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("retired", 32'(retired), 32'(m_ret % 65536));
    chk("retired4", 32'(e_retired), 32'(m_ret % 16));
    chk("state4", 32'(e_state), 32'(m_st));
  endtask

  // Called at a negedge: drive, check, update model, wait for next negedge.
  task automatic cycle(input bit r, input bit s, input bit rdy, input logic [7:0] ins);
    run = r; step = s; mem_ready = rdy; instruction = ins;
    #1;
    check_now();
    model_clock();
    @(negedge CLK);
  endtask

  task automatic async_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; run = 1'b1; step = 1'b0; mem_ready = 1'b0; instruction = 8'h00;
    #2;
    chk("init_state", 32'(state), 32'd1);
    chk("init_retired", 32'(retired), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;

    // add r3=r1+r2: 4 cycles
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 8'b00_01_10_11);
    chk("add_latency", 32'(retired), 32'd1);
    // lw with 3 stalled MEM cycles: 8 cycles
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'b01_00_01_11);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'b01_00_01_11);
    for (int i = 0; i < 2; i++) cycle(1, 0, 1, 8'b01_00_01_11);
    chk("lw_latency", 32'(retired), 32'd2);
    // sw: 4 cycles
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 8'b10_00_01_01);
    chk("sw_latency", 32'(retired), 32'd3);
    // jmp x2: 2 cycles each
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 8'b11_101010);
    chk("jmp_latency", 32'(retired), 32'd5);
    // run drops: finish add, go idle; step runs one add; step while busy ignored
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 8'b00_01_10_11);
    chk("idle_after_run", 32'(state), 32'd0);
    cycle(0, 1, 1, 8'b00_01_10_11);
    cycle(0, 0, 1, 8'b00_01_10_11);
    cycle(0, 1, 1, 8'b00_01_10_11);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'b00_01_10_11);
    chk("step_one", 32'(retired), 32'd7);
    chk("step_idle", 32'(state), 32'd0);

    // FETCH timeout
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 8'h00);
    chk("tmo_state", 32'(state), 32'd7);
    chk("tmo_fault", 32'(fault), 32'd1);
    async_reset();

    // MEM timeout on lw
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8'b01_00_01_11);
    for (int i = 0; i < 18; i++) cycle(1, 0, 0, 8'b01_00_01_11);
    chk("mem_tmo_state", 32'(state), 32'd7);
    async_reset();

    // Randomized blocks, each ending in an asynchronous reset mid-instruction
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 600; i++) begin
        bit r;
        r = (b % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 15) != 0);
        cycle(r, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      end
      async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
